// File: rtl/water_level_meter.sv
// rtl/water_level_meter.sv - ultrasonic echo timer producing a 4-bit water level
// Fires a trigger, times the echo in whole metres by counting, reports tank height minus distance.
module water_level_meter #(
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_M   = 294_118,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int TANK_M         = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo,
    output logic       trig,
    output logic [3:0] water_level_int,
    output logic       level_valid,
    output logic       sensor_err
);

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE
    } state_t;

    localparam logic [3:0] TANK = 4'(TANK_M);

    state_t      state;
    state_t      next_state;
    logic        echo_sync1;
    logic        echo_s;
    logic        echo_prev;
    logic        rise;
    logic        fall;
    logic        to_hit;
    logic        count_en;
    logic        done;
    logic        fault;
    logic [31:0] phase_cnt;
    logic [31:0] to_cnt;
    logic [31:0] sub_cnt;
    logic [3:0]  m_cnt;

    assign rise   = echo_s & ~echo_prev;
    assign fall   = ~echo_s & echo_prev;
    // Fires on the edge at which the timeout counter would reach its limit.
    assign to_hit = (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        next_state = state;
        count_en   = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: begin
                if (phase_cnt == 32'(GAP_CYCLES)) begin
                    next_state = TRIG;
                end
            end
            TRIG: begin
                if (phase_cnt == 32'(TRIG_CYCLES - 1)) begin
                    next_state = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (to_hit) begin
                    next_state = IDLE;
                    fault      = 1'b1;
                end else if (rise) begin
                    // The rise cycle is the first echo-high cycle.
                    next_state = MEASURE;
                    count_en   = 1'b1;
                end
            end
            MEASURE: begin
                // A fall coinciding with timeout counts as a good measurement.
                if (fall) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else if (to_hit) begin
                    next_state = IDLE;
                    fault      = 1'b1;
                end else begin
                    count_en = echo_s;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            echo_sync1      <= 1'b0;
            echo_s          <= 1'b0;
            echo_prev       <= 1'b0;
            phase_cnt       <= 32'd0;
            to_cnt          <= 32'd0;
            sub_cnt         <= 32'd0;
            m_cnt           <= 4'd0;
            trig            <= 1'b0;
            water_level_int <= 4'd0;
            level_valid     <= 1'b0;
            sensor_err      <= 1'b0;
        end else begin
            state       <= next_state;
            echo_sync1  <= echo;
            echo_s      <= echo_sync1;
            echo_prev   <= echo_s;
            trig        <= (next_state == TRIG);
            level_valid <= done;

            if (state != next_state) begin
                phase_cnt <= 32'd0;
            end else if (state == IDLE || state == TRIG) begin
                phase_cnt <= phase_cnt + 32'd1;
            end

            if (state == TRIG) begin
                to_cnt  <= 32'd0;
                sub_cnt <= 32'd0;
                m_cnt   <= 4'd0;
            end else begin
                if (state == WAIT_RISE || state == MEASURE) begin
                    to_cnt <= to_cnt + 32'd1;
                end
                if (count_en) begin
                    if (sub_cnt == 32'(CYCLES_PER_M - 1)) begin
                        sub_cnt <= 32'd0;
                        if (m_cnt != 4'hF) begin
                            m_cnt <= m_cnt + 4'd1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 32'd1;
                    end
                end
            end

            if (done) begin
                water_level_int <= (m_cnt >= TANK) ? 4'd0 : TANK - m_cnt;
                sensor_err      <= 1'b0;
            end else if (fault) begin
                sensor_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_water_level_meter.sv
// tb/tb_water_level_meter.sv - directed vector bench for water_level_meter
module tb_water_level_meter;

    localparam int GAP   = 20;
    localparam int TRIGC = 5;
    localparam int CPM   = 10;
    localparam int TO    = 200;
    localparam int LIMIT = 1000;

    typedef struct {
        string      name;
        int         width;
        int         mode;      // 0 echo pulse, 1 no echo, 2 echo stuck high
        logic [3:0] lvl;       // expected level, TANK_M=15 instance
        logic [3:0] lvl9;      // expected level, TANK_M=9 instance
        logic       prev_err;  // sensor_err expected just before a timeout
    } meas_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       echo;
    logic       trig;
    logic       level_valid;
    logic       sensor_err;
    logic [3:0] water_level_int;
    logic       trig9;
    logic       level_valid9;
    logic       sensor_err9;
    logic [3:0] water_level9;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    meas_t vec[9];
    meas_t b2b[4];

    water_level_meter #(
        .GAP_CYCLES(GAP), .TRIG_CYCLES(TRIGC), .CYCLES_PER_M(CPM),
        .TIMEOUT_CYCLES(TO), .TANK_M(15)
    ) dut (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig),
        .water_level_int(water_level_int), .level_valid(level_valid), .sensor_err(sensor_err)
    );

    water_level_meter #(
        .GAP_CYCLES(GAP), .TRIG_CYCLES(TRIGC), .CYCLES_PER_M(CPM),
        .TIMEOUT_CYCLES(TO), .TANK_M(9)
    ) dut9 (
        .clk(clk), .rst(rst), .echo(echo), .trig(trig9),
        .water_level_int(water_level9), .level_valid(level_valid9), .sensor_err(sensor_err9)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (level_valid) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_trig_rise(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (trig == 1'b0 && k < LIMIT);
    endtask

    task automatic trig_width(output int len);
        len = 0;
        while (trig == 1'b1 && len < 100) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic run_meas(input meas_t v, input bit skip_rise);
        int k;
        int len;
        int p0;
        p0 = pulses;
        if (!skip_rise) begin
            wait_trig_rise(k);
            if (k >= LIMIT) begin
                check({v.name, " trig_rise_timeout"}, k, 0);
                return;
            end
        end
        if (v.mode == 2) echo = 1'b1;
        trig_width(len);
        check({v.name, " trig_width"}, len, TRIGC);
        if (v.mode == 0) begin
            repeat (30) @(negedge clk);
            echo = 1'b1;
            repeat (v.width) @(negedge clk);
            echo = 1'b0;
            @(negedge clk);
            check({v.name, " valid_edge1"}, level_valid, 0);
            @(negedge clk);
            check({v.name, " valid_edge2"}, level_valid, 0);
            @(negedge clk);
            check({v.name, " valid_edge3"}, level_valid, 1);
            check({v.name, " level"}, water_level_int, v.lvl);
            check({v.name, " level_tank9"}, water_level9, v.lvl9);
            check({v.name, " err_cleared"}, sensor_err, 0);
            @(negedge clk);
            check({v.name, " valid_one_cycle"}, level_valid, 0);
        end else begin
            for (int i = 1; i <= TO; i++) begin
                @(negedge clk);
                if (i == TO - 1) check({v.name, " err_before_timeout"}, sensor_err, v.prev_err);
            end
            check({v.name, " err_at_timeout"}, sensor_err, 1);
            check({v.name, " err_at_timeout_tank9"}, sensor_err9, 1);
            check({v.name, " level_held"}, water_level_int, v.lvl);
            check({v.name, " level_held_tank9"}, water_level9, v.lvl9);
            echo = 1'b0;
        end
        check({v.name, " valid_pulses"}, pulses - p0, (v.mode == 0) ? 1 : 0);
    endtask

    initial begin
        int k;
        int len;
        int p0;

        vec[0] = '{"w42",      42,  0, 4'd11, 4'd5, 1'b0};
        vec[1] = '{"w5",       5,   0, 4'd15, 4'd9, 1'b0};
        vec[2] = '{"w10",      10,  0, 4'd14, 4'd8, 1'b0};
        vec[3] = '{"w160_sat", 160, 0, 4'd0,  4'd0, 1'b0};
        vec[4] = '{"w120",     120, 0, 4'd3,  4'd0, 1'b0};
        vec[5] = '{"w42_again", 42, 0, 4'd11, 4'd5, 1'b0};
        vec[6] = '{"no_echo",  0,   1, 4'd11, 4'd5, 1'b0};
        vec[7] = '{"stuck",    0,   2, 4'd11, 4'd5, 1'b1};
        vec[8] = '{"recover",  42,  0, 4'd11, 4'd5, 1'b0};

        b2b[0] = '{"b2b_w42",  42,  0, 4'd11, 4'd5, 1'b0};
        b2b[1] = '{"b2b_w73",  73,  0, 4'd8,  4'd2, 1'b0};
        b2b[2] = '{"b2b_to",   0,   1, 4'd8,  4'd2, 1'b0};
        b2b[3] = '{"b2b_w139", 139, 0, 4'd2,  4'd0, 1'b0};

        rst  = 1'b1;
        echo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_trig", trig, 0);
            check("reset_level", water_level_int, 0);
            check("reset_valid", level_valid, 0);
            check("reset_err", sensor_err, 0);
        end
        rst = 1'b0;
        wait_trig_rise(k);
        check("trig_rise_edge", k, GAP + 1);

        for (int i = 0; i < 9; i++) run_meas(vec[i], i == 0);

        wait_trig_rise(k);
        trig_width(len);
        repeat (30) @(negedge clk);
        echo = 1'b1;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_trig", trig, 0);
        check("midreset_level", water_level_int, 0);
        check("midreset_level_tank9", water_level9, 0);
        check("midreset_valid", level_valid, 0);
        check("midreset_err", sensor_err, 0);
        echo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_trig_rise(k);
        check("midreset_trig_rise_edge", k, GAP + 1);

        p0 = pulses;
        for (int i = 0; i < 4; i++) run_meas(b2b[i], i == 0);
        check("b2b_total_pulses", pulses - p0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/water_level_meter.md
# water_level_meter

Ultrasonic water-level front end that produces the 4-bit level consumed by the dot-matrix display and alarm logic. It periodically fires a trigger pulse, times the returning echo pulse, converts echo width to distance in whole metres by repeated counting (no divider), and outputs `water_level_int` as tank height minus distance, in metres. It runs on the board clock and flags a sensor fault on missing or stuck echoes.

## Interface
- `GAP_CYCLES`, default 3_000_000: idle cycles between measurements (60 ms at 50 MHz).
- `TRIG_CYCLES`, default 500: trigger pulse width in cycles (10 µs).
- `CYCLES_PER_M`, default 294_118: echo-high cycles per metre of distance.
- `TIMEOUT_CYCLES`, default 2_500_000: maximum cycles allowed in WAIT_RISE plus MEASURE combined.
- `TANK_M`, default 15: sensor-to-tank-floor distance in metres; legal range 1..15.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `echo`  in  1: raw sensor echo, asynchronous to `clk`.
- `trig`  out  1: sensor trigger, registered.
- `water_level_int`  out  4: latest valid level, 0..15 m.
- `level_valid`  out  1: one-cycle pulse when `water_level_int` updates.
- `sensor_err`  out  1: sticky fault flag; cleared by the next good measurement.

## Operation
- `echo` passes through a 2-flop synchronizer to `echo_s`. A rising edge is `echo_s` high with the previous `echo_s` low; a falling edge is the reverse.
- Reset state: IDLE. All counters are 0. `trig`=0, `water_level_int`=0, `level_valid`=0, `sensor_err`=0.
- IDLE: count `GAP_CYCLES` cycles, then go to TRIG.
- TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. Clear the timeout counter, `sub_cnt`, and `m_cnt`.
- WAIT_RISE: increment the timeout counter each cycle.
  - On a rising edge, go to MEASURE. The rise cycle counts as the first echo-high cycle.
  - When the timeout counter reaches `TIMEOUT_CYCLES`, set `sensor_err`=1 and go to IDLE.
  - An echo already high when entering WAIT_RISE produces no rising edge and ends in a timeout.
- MEASURE: for each cycle with `echo_s` high, `sub_cnt` increments.
  - When `sub_cnt` equals `CYCLES_PER_M`-1, it wraps to 0 and `m_cnt` increments.
  - `m_cnt` is 4 bits and saturates at 15.
  - The timeout counter keeps running. On timeout, set `sensor_err`=1 and go to IDLE without updating the level.
- On a falling edge:
  - `water_level_int` ← (`m_cnt` ≥ `TANK_M`) ? 0 : `TANK_M` − `m_cnt`.
  - Pulse `level_valid` for 1 cycle and clear `sensor_err`.
  - Go to IDLE.
- Arithmetic: `m_cnt` = floor(echo-high cycles / `CYCLES_PER_M`), saturating at 15. The result is always in 0..15, so no overflow is possible.
- On a fault, `water_level_int` holds its last valid value.
- Simultaneous events: a falling edge and a timeout in the same cycle resolve as the falling edge (good measurement).
- `rst` mid-operation: on the next edge, all outputs and state return to reset values, `trig` drops immediately, and the gap restarts from 0.

## Timing
- After `rst` deasserts, `trig` rises at edge `GAP_CYCLES`+1 and stays high for `TRIG_CYCLES` cycles.
- The synchronizer delays both echo edges by 2 cycles, so the measured width equals the raw width in cycles.
- Update latency: `level_valid` and the new `water_level_int` appear 3 edges after the first edge that samples raw `echo` low (sync1, sync2, output register).
- `sensor_err` asserts on the edge at which the timeout counter reaches `TIMEOUT_CYCLES`. No `level_valid` pulse occurs for that measurement.
- Measurement period = `GAP_CYCLES` + `TRIG_CYCLES` + WAIT_RISE time + MEASURE time + 1 cycle for the DONE transition into IDLE.

## Test plan
Bench parameters: `GAP_CYCLES`=20, `TRIG_CYCLES`=5, `CYCLES_PER_M`=10, `TIMEOUT_CYCLES`=200, `TANK_M`=15.
- Reset and trigger: hold `rst` for 3 cycles, then release. All outputs are 0 during reset. `trig` is high for exactly 5 cycles starting at edge 21 after release.
- Normal measurement: drive `echo` high for 42 cycles, 30 cycles after `trig` falls. Expect `water_level_int`=11 and one `level_valid` pulse, 3 edges after `echo` falls.
- Boundaries:
  - Echo width 5 gives level 15.
  - Echo width 10 gives level 14.
  - Echo width 160 saturates `m_cnt` at 15 and gives level 0.
  - With `TANK_M`=9 and width 120, level is 0.
- Faults:
  - No echo: `sensor_err`=1 200 cycles after entering WAIT_RISE, level held at 11, no valid pulse.
  - Echo stuck high: same fault result.
  - The next 42-cycle echo clears `sensor_err` and sets level 11.
- Reset mid-MEASURE (echo high for 25 cycles, then `rst`): all outputs return to 0 on the next edge, and a fresh trigger follows 21 edges after release.
- Back-to-back measurements: widths 42, 73, 0 (timeout), 139. Expected levels 11, 8, hold 8 with `sensor_err`, then 2 with `sensor_err` cleared. Exactly 3 `level_valid` pulses in total.
